// File: rtl/mips_trace_buffer.sv
// Trace buffer for the single-cycle MIPS core: captures {PC, ALU, DMEM} records into a circular
// FIFO and streams them out one 32-bit word per handshake. Optional macro: TRACE_TRIGGER_EN.
module mips_trace_buffer #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DROP_W     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  capture_en,
  input  logic [31:0]           PC_in,
  input  logic [31:0]           ALU_in,
  input  logic [31:0]           d_mem_in,
`ifdef TRACE_TRIGGER_EN
  input  logic [31:0]           trigger_pc,
  output logic                  triggered,
`endif
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [31:0]           out_data,
  output logic [1:0]            out_word_sel,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_count
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [1:0] {WPc = 2'd0, WAlu = 2'd1, WDmem = 2'd2} word_e;

  word_e                 state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_W-1:0]     drop_q, drop_d;

  logic [31:0] mem_pc  [Depth];
  logic [31:0] mem_alu [Depth];
  logic [31:0] mem_dm  [Depth];

  logic push_req, push, pop, drop, handshake;

`ifdef TRACE_TRIGGER_EN
  logic triggered_q, triggered_d, pc_match;
  assign pc_match    = (PC_in == trigger_pc);
  assign triggered_d = triggered_q | (capture_en & pc_match);
  // The matching record itself is captured, not only the ones after it.
  assign push_req    = capture_en & (triggered_q | pc_match);
  assign triggered   = triggered_q;
`else
  assign push_req = capture_en;
`endif

  assign handshake = out_valid & out_ready;
  assign pop       = handshake & (state_q == WDmem);
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push      = push_req & ((count_q != DepthCnt) | pop);
  assign drop      = push_req & ~push;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= WPc;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
`ifdef TRACE_TRIGGER_EN
      triggered_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
`ifdef TRACE_TRIGGER_EN
      triggered_q <= triggered_d;
`endif
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_pc[wr_ptr_q]  <= PC_in;
      mem_alu[wr_ptr_q] <= ALU_in;
      mem_dm[wr_ptr_q]  <= d_mem_in;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (handshake) begin
      case (state_q)
        WPc:     state_d = WAlu;
        WAlu:    state_d = WDmem;
        WDmem:   state_d = WPc;
        default: state_d = WPc;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
    if (drop && !(&drop_q)) drop_d = drop_q + 1'b1;
  end

  // Output logic
  always_comb begin
    out_valid    = (count_q != '0);
    out_word_sel = state_q;
    out_data     = '0;
    if (out_valid) begin
      case (state_q)
        WPc:     out_data = mem_pc[rd_ptr_q];
        WAlu:    out_data = mem_alu[rd_ptr_q];
        WDmem:   out_data = mem_dm[rd_ptr_q];
        default: out_data = '0;
      endcase
    end
  end

  assign count      = count_q;
  assign full       = (count_q == DepthCnt);
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer: vector table, directed corner sequences and a
// queue-based record scoreboard compared against the outputs every cycle.
module tb_mips_trace_buffer;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int DW    = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          capture_en;
  logic [31:0]   PC_in, ALU_in, d_mem_in;
  logic          out_ready;
  logic          out_valid;
  logic [31:0]   out_data;
  logic [1:0]    out_word_sel;
  logic [DL2:0]  count;
  logic          full;
  logic          overflow;
  logic [DW-1:0] drop_count;
`ifdef TRACE_TRIGGER_EN
  logic [31:0]   trigger_pc;
  logic          triggered;
`endif

  mips_trace_buffer #(.DEPTH_LOG2(DL2), .DROP_W(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .capture_en   (capture_en),
    .PC_in        (PC_in),
    .ALU_in       (ALU_in),
    .d_mem_in     (d_mem_in),
`ifdef TRACE_TRIGGER_EN
    .trigger_pc   (trigger_pc),
    .triggered    (triggered),
`endif
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_word_sel (out_word_sel),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: accepted records in order, plus the expected word index and drop state.
  logic [95:0] mq[$];
  int          m_sel;
  bit          m_ovf;
  int          m_drop;
  bit          m_trig;

  typedef struct {
    logic        cap;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dm;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_data;
    logic [1:0]  e_sel;
    logic [4:0]  e_count;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic cap, input logic [31:0] pc, input logic [31:0] alu,
                     input logic [31:0] dm, input logic rdy);
    capture_en = cap;
    PC_in      = pc;
    ALU_in     = alu;
    d_mem_in   = dm;
    out_ready  = rdy;
`ifdef TRACE_TRIGGER_EN
    trigger_pc = pc;
`endif
  endtask

  task automatic model_edge();
    bit hs, pop, preq, acc;
    if (reset) begin
      mq.delete();
      m_sel  = 0;
      m_ovf  = 0;
      m_drop = 0;
      m_trig = 0;
      return;
    end
    hs  = (mq.size() != 0) && out_ready;
    pop = hs && (m_sel == 2);
`ifdef TRACE_TRIGGER_EN
    preq = capture_en && (m_trig || PC_in == trigger_pc);
    if (capture_en && PC_in == trigger_pc) m_trig = 1;
`else
    preq = capture_en;
`endif
    acc = preq && ((mq.size() < DEPTH) || pop);
    if (hs) m_sel = (m_sel == 2) ? 0 : m_sel + 1;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back({PC_in, ALU_in, d_mem_in});
    else if (preq) begin
      m_ovf = 1;
      if (m_drop != (1 << DW) - 1) m_drop++;
    end
  endtask

  task automatic check_model();
    logic [95:0] r;
    logic [31:0] ed;
    ed = '0;
    if (mq.size() != 0) begin
      r  = mq[0];
      ed = (m_sel == 0) ? r[95:64] : (m_sel == 1) ? r[63:32] : r[31:0];
    end
    chk("sb_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("sb_data", out_data, ed);
    chk("sb_sel", 32'(out_word_sel), 32'(m_sel));
    chk("sb_count", 32'(count), 32'(mq.size()));
    chk("sb_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("sb_overflow", 32'(overflow), 32'(m_ovf));
    chk("sb_drop", 32'(drop_count), 32'(m_drop));
`ifdef TRACE_TRIGGER_EN
    chk("sb_triggered", 32'(triggered), 32'(m_trig));
`endif
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_model();
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] last_pc;
    int          n;
    logic [DW-1:0] drop_before;

    vecs[0] = '{1'b1, 32'h4, 32'hA, 32'h0, 1'b1, 1'b1, 32'h4, 2'd0, 5'd1};
    vecs[1] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hA, 2'd1, 5'd1};
    vecs[2] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 2'd2, 5'd1};
    vecs[3] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 2'd0, 5'd0};

    reset = 1'b1;
    drv(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc();
    cyc();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", out_data, 32'd0);
    reset = 1'b0;

    // Single record drained word by word
    for (int i = 0; i < 4; i++) begin
      drv(vecs[i].cap, vecs[i].pc, vecs[i].alu, vecs[i].dm, vecs[i].rdy);
      cyc();
      chk("vec_valid", 32'(out_valid), 32'(vecs[i].e_valid));
      chk("vec_data", out_data, vecs[i].e_data);
      chk("vec_sel", 32'(out_word_sel), 32'(vecs[i].e_sel));
      chk("vec_count", 32'(count), 32'(vecs[i].e_count));
    end

    // Overflow: 20 captures into 16 slots, then full drain in order
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 32'(i * 4), 32'(i * 4 + 1), 32'(i * 4 + 2), 1'b0);
      cyc();
    end
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_count), 32'd4);
    n = 0;
    for (int i = 0; i < 52; i++) begin
      drv(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      if (out_valid && out_word_sel == 2'd0) begin
        chk("drain_pc", out_data, 32'(n * 4));
        n++;
      end
      cyc();
    end
    chk("drain_records", 32'(n), 32'd16);

    // Backpressure: ready on alternate cycles
    drv(1'b1, 32'h40, 32'h41, 32'h42, 1'b0);
    cyc();
    for (int i = 0; i < 6; i++) begin
      drv(1'b0, 32'h0, 32'h0, 32'h0, 1'(i % 2));
      held = out_data;
      cyc();
      if (i % 2 == 0) chk("bp_hold", out_data, held);
      if (i == 4) chk("bp_count_mid", 32'(count), 32'd1);
    end
    chk("bp_count_end", 32'(count), 32'd0);

    // Full FIFO with pop and push on the same edge
    reset = 1'b1;
    drv(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 32'(32'h200 + i * 4), 32'h1, 32'h2, 1'b0);
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      drv(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      cyc();
    end
    chk("fp_sel", 32'(out_word_sel), 32'd2);
    drop_before = drop_count;
    drv(1'b1, 32'h300, 32'h301, 32'h302, 1'b1);
    cyc();
    chk("fp_count", 32'(count), 32'd16);
    chk("fp_full", 32'(full), 32'd1);
    chk("fp_drop", 32'(drop_count), 32'(drop_before));
    last_pc = '0;
    for (int i = 0; i < 50; i++) begin
      drv(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      if (out_valid && out_word_sel == 2'd0) last_pc = out_data;
      cyc();
    end
    chk("fp_last_pc", last_pc, 32'h300);

    // Reset in W_ALU with 5 records stored and drops recorded
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 32'(32'h400 + i * 4), 32'h5, 32'h6, 1'b0);
      cyc();
    end
    for (int i = 0; i < 33; i++) begin
      drv(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      cyc();
    end
    chk("rs_count_pre", 32'(count), 32'd5);
    drv(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    cyc();
    chk("rs_sel_pre", 32'(out_word_sel), 32'd1);
    reset = 1'b1;
    drv(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc();
    reset = 1'b0;
    chk("rs_count", 32'(count), 32'd0);
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_overflow", 32'(overflow), 32'd0);
    chk("rs_drop", 32'(drop_count), 32'd0);
    chk("rs_sel", 32'(out_word_sel), 32'd0);
    drv(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    cyc();
    chk("rs_no_replay", 32'(out_valid), 32'd0);

`ifdef TRACE_TRIGGER_EN
    // Trigger: capture starts at the matching PC
    reset = 1'b1;
    drv(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 32'(i * 4), 32'(i), 32'(i + 100), 1'b0);
      trigger_pc = 32'h10;
      cyc();
      chk("trig_flag", 32'(triggered), 32'(i >= 4));
    end
    chk("trig_count", 32'(count), 32'd4);
    chk("trig_first_pc", out_data, 32'h10);
    for (int i = 0; i < 14; i++) begin
      drv(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
      trigger_pc = 32'h10;
      cyc();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
